// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Desc     : Shared types and encodings for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [1:0] FMT_B = 2'b00;
    localparam logic [1:0] FMT_H = 2'b01;
    localparam logic [1:0] FMT_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3 encodings with no RV32I load/store meaning
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_SW);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Desc     : Request, response and RAM data-port signals of the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic [4:0]            resp_rd;
    logic                  resp_err;

    logic                  mem_we;
    logic [1:0]            mem_format;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // slave: the LSU itself; master: execute, writeback and RAM side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        output mem_we, mem_format, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        input  mem_we, mem_format, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ext
// Desc     : Combinational sign/zero extender for load data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [2:0]            i_funct3,
    input  wire logic [DATA_WIDTH-1:0] i_raw_data,
    output logic      [DATA_WIDTH-1:0] o_ext_data
);

    always_comb begin
        o_ext_data = i_raw_data;
        case (i_funct3)
            F3_LB:   o_ext_data = {{(DATA_WIDTH-8){i_raw_data[7]}},   i_raw_data[7:0]};
            F3_LH:   o_ext_data = {{(DATA_WIDTH-16){i_raw_data[15]}}, i_raw_data[15:0]};
            F3_LBU:  o_ext_data = {{(DATA_WIDTH-8){1'b0}},            i_raw_data[7:0]};
            F3_LHU:  o_ext_data = {{(DATA_WIDTH-16){1'b0}},           i_raw_data[15:0]};
            default: o_ext_data = i_raw_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Desc     : One-deep load/store unit between execute and the RAM data port.
// Config   : define LSU_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_if.slave      bus
);

    localparam logic [3:0] c_lat_init = 4'(MEM_LAT - 1);

    lsu_state_e            r_state;
    logic [3:0]            r_lat_cnt;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [4:0]            r_resp_rd;
    logic                  r_resp_err;
    logic                  r_mem_we;
    logic [1:0]            r_mem_format;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_ext;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((bus.req_funct3[1:0] == FMT_H) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == FMT_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // r_req_ready is only ever set while in IDLE
    assign w_accept = bus.req_valid && r_req_ready;
    assign w_err    = f3_illegal(bus.req_we, bus.req_funct3) || w_misalign;

    lsu_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ext (
        .i_funct3   (r_funct3),
        .i_raw_data (bus.mem_rdata),
        .o_ext_data (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lat_cnt    <= 4'd0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_format <= 2'b00;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_we         <= bus.req_we;
                        r_funct3     <= bus.req_funct3;
                        r_resp_rd    <= bus.req_rd;
                        r_resp_rdata <= '0;
                        r_resp_err   <= w_err;
                        if (w_err) begin
                            // errors skip the RAM entirely
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state      <= ACCESS;
                            r_lat_cnt    <= c_lat_init;
                            r_mem_we     <= bus.req_we;
                            r_mem_format <= bus.req_funct3[1:0];
                            r_mem_addr   <= bus.req_addr;
                            r_mem_wdata  <= bus.req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_mem_we     <= 1'b0;
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end else if (r_lat_cnt == 4'd0) begin
                        r_resp_rdata <= w_ext;
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_format = r_mem_format;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Desc     : Directed self-checking bench; one LSU with MEM_LAT=1, one with 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
    import lsu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
    lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b4 ();

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_funct3 = 3'd0; b1.req_addr = '0;
        b1.req_wdata = '0;   b1.req_rd = 5'd0; b1.resp_ready = 1'b1; b1.mem_rdata = '0;
        b4.req_valid = 1'b0; b4.req_we = 1'b0; b4.req_funct3 = 3'd0; b4.req_addr = '0;
        b4.req_wdata = '0;   b4.req_rd = 5'd0; b4.resp_ready = 1'b1; b4.mem_rdata = '0;
    endtask

    // returns #1 after the accepting edge T0
    task automatic req1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        @(posedge clk); #1;
        b1.req_valid = 1'b1; b1.req_we = we; b1.req_funct3 = f3;
        b1.req_addr = addr;  b1.req_wdata = wdata; b1.req_rd = rd;
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
    endtask

    task automatic req4(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        @(posedge clk); #1;
        b4.req_valid = 1'b1; b4.req_we = we; b4.req_funct3 = f3;
        b4.req_addr = addr;  b4.req_wdata = wdata; b4.req_rd = rd;
        @(posedge clk); #1;
        b4.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [106:0] v1, v4;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        v1 = {b1.req_ready, b1.resp_valid, b1.resp_err, b1.mem_we, b1.mem_format,
              b1.mem_addr, b1.mem_wdata, b1.resp_rdata, b1.resp_rd};
        v4 = {b4.req_ready, b4.resp_valid, b4.resp_err, b4.mem_we, b4.mem_format,
              b4.mem_addr, b4.mem_wdata, b4.resp_rdata, b4.resp_rd};
        total++; if (v1 !== '0) begin bad++; $display("FAIL reset_outputs_lat1 got=%h exp=0", v1); end
        total++; if (v4 !== '0) begin bad++; $display("FAIL reset_outputs_lat4 got=%h exp=0", v4); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if ({b1.req_ready, b4.req_ready} !== 2'b11) begin
            bad++; $display("FAIL reset_release_ready got=%b exp=11", {b1.req_ready, b4.req_ready});
        end
    endtask

    task automatic test_misalign();
        b1.mem_rdata = 32'h0000_7FFF;
        req1(1'b0, F3_LH, 32'h8000_0001, 32'h0, 5'd7);
        @(negedge clk);
`ifdef LSU_MISALIGN_CHECK_EN
        total++; if ({b1.resp_valid, b1.resp_err, b1.mem_we} !== 3'b110) begin
            bad++; $display("FAIL misalign_err got=%b exp=110", {b1.resp_valid, b1.resp_err, b1.mem_we});
        end
        total++; if ({b1.mem_addr, b1.resp_rdata} !== 64'h0) begin
            bad++; $display("FAIL misalign_no_access got=%h exp=0", {b1.mem_addr, b1.resp_rdata});
        end
        @(posedge clk); #1;
`else
        total++; if ({b1.resp_valid, b1.mem_we, b1.mem_format} !== 4'b0001) begin
            bad++; $display("FAIL misalign_issue got=%b exp=0001", {b1.resp_valid, b1.mem_we, b1.mem_format});
        end
        total++; if (b1.mem_addr !== 32'h8000_0001) begin
            bad++; $display("FAIL misalign_addr got=%h exp=80000001", b1.mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({b1.resp_valid, b1.resp_err, b1.resp_rdata} !== {2'b10, 32'h0000_7FFF}) begin
            bad++; $display("FAIL misalign_resp got=%b/%b/%h exp=1/0/00007fff",
                            b1.resp_valid, b1.resp_err, b1.resp_rdata);
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_illegal();
        logic       wes [2] = '{1'b1, 1'b0};
        logic [2:0] f3s [2] = '{3'b011, 3'b110};
        for (int i = 0; i < 2; i++) begin
            b1.mem_rdata = 32'hFFFF_FFFF;
            req1(wes[i], f3s[i], 32'h8000_0004, 32'h1234_5678, 5'd2);
            @(negedge clk);
            total++; if ({b1.resp_valid, b1.resp_err, b1.mem_we, b1.resp_rdata} !== {3'b110, 32'h0}) begin
                bad++; $display("FAIL illegal_f3_%0d got=%b/%b/%b/%h exp=1/1/0/0", i,
                                b1.resp_valid, b1.resp_err, b1.mem_we, b1.resp_rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        req1(1'b1, F3_SW, 32'h8000_0010, 32'hDEAD_BEEF, 5'd3);
        @(negedge clk);
        total++; if ({b1.mem_we, b1.mem_format, b1.resp_valid, b1.req_ready} !== 5'b11000) begin
            bad++; $display("FAIL store_t1_ctrl got=%b exp=11000",
                            {b1.mem_we, b1.mem_format, b1.resp_valid, b1.req_ready});
        end
        total++; if ({b1.mem_addr, b1.mem_wdata} !== {32'h8000_0010, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL store_t1_bus got=%h/%h exp=80000010/deadbeef", b1.mem_addr, b1.mem_wdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({b1.mem_we, b1.resp_valid, b1.resp_err, b1.resp_rd, b1.resp_rdata} !==
                     {3'b010, 5'd3, 32'h0}) begin
            bad++; $display("FAIL store_t2_resp got=%b/%b/%b/%0d/%h exp=0/1/0/3/0",
                            b1.mem_we, b1.resp_valid, b1.resp_err, b1.resp_rd, b1.resp_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({b1.resp_valid, b1.req_ready, b1.mem_we} !== 3'b010) begin
            bad++; $display("FAIL store_t3_idle got=%b exp=010", {b1.resp_valid, b1.req_ready, b1.mem_we});
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB};
        logic [31:0] raw [6] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001,
                                 32'h0000_8001, 32'h89AB_CDEF, 32'h0000_007F};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                 32'h0000_8001, 32'h89AB_CDEF, 32'h0000_007F};
        logic [1:0]  fmt [6] = '{FMT_B, FMT_B, FMT_H, FMT_H, FMT_W, FMT_B};
        for (int i = 0; i < 6; i++) begin
            b1.mem_rdata = raw[i];
            req1(1'b0, f3s[i], 32'h8000_0020, 32'h0, 5'(i + 1));
            @(negedge clk);
            total++; if ({b1.mem_we, b1.mem_format, b1.mem_addr} !== {1'b0, fmt[i], 32'h8000_0020}) begin
                bad++; $display("FAIL load_access_%0d got=%b/%b/%h exp=0/%b/80000020", i,
                                b1.mem_we, b1.mem_format, b1.mem_addr, fmt[i]);
            end
            @(posedge clk); #1;
            @(negedge clk);
            total++; if ({b1.resp_valid, b1.resp_err, b1.resp_rdata} !== {2'b10, exp[i]}) begin
                bad++; $display("FAIL load_ext_%0d got=%b/%b/%h exp=1/0/%h", i,
                                b1.resp_valid, b1.resp_err, b1.resp_rdata, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency();
        logic [31:0] vals [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hCAFE_F00D};
        req4(1'b0, F3_LW, 32'h8000_0040, 32'h0, 5'd5);
        for (int i = 0; i < 4; i++) begin
            b4.mem_rdata = vals[i];
            @(negedge clk);
            total++; if ({b4.resp_valid, b4.req_ready, b4.mem_we, b4.mem_format, b4.mem_addr} !==
                         {5'b00010, 32'h8000_0040}) begin
                bad++; $display("FAIL latency_access_t%0d got=%b/%b/%b/%b/%h exp=0/0/0/10/80000040", i + 1,
                                b4.resp_valid, b4.req_ready, b4.mem_we, b4.mem_format, b4.mem_addr);
            end
            @(posedge clk); #1;
        end
        b4.mem_rdata = 32'h9999_9999;
        @(negedge clk);
        total++; if ({b4.resp_valid, b4.resp_rd, b4.resp_rdata} !== {1'b1, 5'd5, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL latency_resp got=%b/%0d/%h exp=1/5/cafef00d",
                            b4.resp_valid, b4.resp_rd, b4.resp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        b1.resp_ready = 1'b0;
        b1.mem_rdata  = 32'hA5A5_0001;
        req1(1'b0, F3_LW, 32'h8000_0050, 32'h0, 5'd12);
        @(negedge clk);
        total++; if (b1.resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_early_valid got=%b exp=0", b1.resp_valid);
        end
        @(posedge clk); #1;
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_funct3 = F3_SB;
        b1.req_addr = 32'h8000_0030; b1.req_wdata = 32'h0000_0055; b1.req_rd = 5'd0;
        b1.mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({b1.resp_valid, b1.req_ready, b1.resp_err, b1.resp_rd, b1.resp_rdata} !==
                         {3'b100, 5'd12, 32'hA5A5_0001}) begin
                bad++; $display("FAIL bp_hold_%0d got=%b/%b/%b/%0d/%h exp=1/0/0/12/a5a50001", i,
                                b1.resp_valid, b1.req_ready, b1.resp_err, b1.resp_rd, b1.resp_rdata);
            end
            @(posedge clk); #1;
        end
        b1.resp_ready = 1'b1;
        @(negedge clk);
        total++; if ({b1.resp_valid, b1.req_ready} !== 2'b10) begin
            bad++; $display("FAIL bp_release got=%b exp=10", {b1.resp_valid, b1.req_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({b1.resp_valid, b1.req_ready, b1.mem_we} !== 3'b010) begin
            bad++; $display("FAIL bp_next_ready got=%b exp=010", {b1.resp_valid, b1.req_ready, b1.mem_we});
        end
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
        @(negedge clk);
        total++; if ({b1.mem_we, b1.mem_format, b1.mem_addr} !== {3'b100, 32'h8000_0030}) begin
            bad++; $display("FAIL bp_next_store got=%b/%b/%h exp=1/00/80000030",
                            b1.mem_we, b1.mem_format, b1.mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (b1.resp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_next_resp got=%b exp=1", b1.resp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int rsp = 0;
        @(posedge clk); #1;
        b1.mem_rdata = 32'h0000_0042;
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_funct3 = F3_LW;
        b1.req_addr = 32'h8000_0060; b1.req_rd = 5'd9;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (b1.req_valid && b1.req_ready) acc++;
            if (b1.resp_valid) begin
                rsp++;
                total++; if (b1.resp_rdata !== 32'h0000_0042) begin
                    bad++; $display("FAIL b2b_rdata_%0d got=%h exp=00000042", i, b1.resp_rdata);
                end
            end
            @(posedge clk); #1;
        end
        b1.req_valid = 1'b0;
        total++; if (acc !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        total++; if (rsp !== 3) begin bad++; $display("FAIL b2b_responses got=%0d exp=3", rsp); end
    endtask

    task automatic test_async_reset();
        logic [106:0] v4;
        logic         seen = 1'b0;
        b4.mem_rdata = 32'h0000_1234;
        req4(1'b0, F3_LW, 32'h8000_0100, 32'h0, 5'd9);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        v4 = {b4.req_ready, b4.resp_valid, b4.resp_err, b4.mem_we, b4.mem_format,
              b4.mem_addr, b4.mem_wdata, b4.resp_rdata, b4.resp_rd};
        total++; if (v4 !== '0) begin bad++; $display("FAIL async_reset_outputs got=%h exp=0", v4); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b4.resp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL async_reset_no_resp got=%b exp=0", seen); end
        total++; if (b4.req_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset_ready got=%b exp=1", b4.req_ready);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_misalign();
        test_illegal();
        test_store();
        test_load_ext();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
